// File: rtl/vga_sync_decoder_if.sv
// Sync-input / recovered-timing bundle between a video source and vga_sync_decoder.
// The master drives the external syncs; the slave (decoder) returns the recovered timing.
interface vga_sync_decoder_if #(
  parameter int HW = 11,
  parameter int VW = 10
);
  logic          HSYNC_IN;
  logic          VSYNC_IN;
  logic [HW-1:0] HCNT;
  logic [VW-1:0] VCNT;
  logic [HW-1:0] HTOTAL;
  logic [VW-1:0] VTOTAL;
  logic          LOCKED;
  logic          ERR;

  modport master (
    output HSYNC_IN, VSYNC_IN,
    input  HCNT, VCNT, HTOTAL, VTOTAL, LOCKED, ERR
  );

  modport slave (
    input  HSYNC_IN, VSYNC_IN,
    output HCNT, VCNT, HTOTAL, VTOTAL, LOCKED, ERR
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers H/V position from asynchronous active-low HSYNC/VSYNC, measures line and
// frame length, and declares lock after LOCK_FRAMES consecutive consistent frames.
module vga_sync_decoder #(
  parameter int HW          = 11,
  parameter int VW          = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  vga_sync_decoder_if.slave     bus
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [HW-1:0] HMAX = '1;
  localparam logic [VW-1:0] VMAX = '1;

  typedef enum logic [1:0] {ST_SEARCH, ST_CHECK, ST_LOCKED} state_e;

  // [0] metastable stage, [1] synchronised, [2] history for edge detect
  logic [2:0]    hs_pipe_q, hs_pipe_d;
  logic [2:0]    vs_pipe_q, vs_pipe_d;
  logic [HW-1:0] hcnt_q, hcnt_d, prev_hlen_q, prev_hlen_d;
  logic [VW-1:0] vcnt_q, vcnt_d, prev_vlen_q, prev_vlen_d;
  logic          hbad_q, hbad_d, sat_q, sat_d, vpend_q, vpend_d;
  logic [HW-1:0] htotal_q, htotal_d;
  logic [VW-1:0] vtotal_q, vtotal_d;
  logic          err_q, err_d;
  state_e        state_q, state_d;
  logic [GW-1:0] gcnt_q, gcnt_d;

  logic          hs_fall, vs_fall, frame_evt, frame_good, sat_now, hmis;
  logic [HW-1:0] hlen;
  logic [VW-1:0] vlen;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    hs_pipe_d   = {hs_pipe_q[1:0], bus.HSYNC_IN};
    vs_pipe_d   = {vs_pipe_q[1:0], bus.VSYNC_IN};
    hs_fall     = hs_pipe_q[2] & ~hs_pipe_q[1];
    vs_fall     = vs_pipe_q[2] & ~vs_pipe_q[1];
    hlen        = hcnt_q + 1'b1;
    vlen        = vcnt_q + 1'b1;
    hmis        = hs_fall && (hlen != prev_hlen_q);
    frame_evt   = hs_fall && (vpend_q || vs_fall);
    sat_now     = (hcnt_q == HMAX) || (vcnt_q == VMAX);
    frame_good  = !(hbad_q || hmis) && (vlen == prev_vlen_q) && !(sat_q || sat_now);

    hcnt_d      = hs_fall ? '0 : ((hcnt_q == HMAX) ? hcnt_q : hcnt_q + 1'b1);
    vcnt_d      = vcnt_q;
    prev_hlen_d = prev_hlen_q;
    prev_vlen_d = prev_vlen_q;
    hbad_d      = hbad_q;
    sat_d       = sat_q || sat_now;
    vpend_d     = vpend_q || vs_fall;

    if (hs_fall) begin
      prev_hlen_d = hlen;
      hbad_d      = hbad_q || hmis;
    end

    // The line that closes a frame is judged in that frame; flags restart for the next.
    if (frame_evt) begin
      vcnt_d      = '0;
      vpend_d     = 1'b0;
      hbad_d      = 1'b0;
      sat_d       = 1'b0;
      prev_vlen_d = vlen;
    end else if (hs_fall && (vcnt_q != VMAX)) begin
      vcnt_d      = vcnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hs_pipe_q   <= '1;  // idle-high so release from reset never fakes a falling edge
      vs_pipe_q   <= '1;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      prev_hlen_q <= '0;
      prev_vlen_q <= '0;
      hbad_q      <= 1'b0;
      sat_q       <= 1'b0;
      vpend_q     <= 1'b0;
    end else begin
      hs_pipe_q   <= hs_pipe_d;
      vs_pipe_q   <= vs_pipe_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      prev_hlen_q <= prev_hlen_d;
      prev_vlen_q <= prev_vlen_d;
      hbad_q      <= hbad_d;
      sat_q       <= sat_d;
      vpend_q     <= vpend_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_SEARCH;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Counter saturation aborts lock at once; otherwise decisions happen only at frame events.
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    if (sat_now) begin
      state_d = ST_SEARCH;
      gcnt_d  = '0;
    end else if (frame_evt) begin
      unique case (state_q)
        ST_SEARCH: begin
          if (frame_good) begin
            gcnt_d  = GW'(1);
            state_d = (LOCK_FRAMES == 1) ? ST_LOCKED : ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (frame_good) begin
            gcnt_d = gcnt_q + 1'b1;
            if (gcnt_d == GW'(LOCK_FRAMES)) state_d = ST_LOCKED;
          end else begin
            state_d = ST_SEARCH;
            gcnt_d  = '0;
          end
        end
        ST_LOCKED: begin
          if (!frame_good) begin
            state_d = ST_SEARCH;
            gcnt_d  = '0;
          end
        end
        default: begin
          state_d = ST_SEARCH;
          gcnt_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    err_d    = (state_q == ST_LOCKED) && (state_d != ST_LOCKED);
    htotal_d = '0;
    vtotal_d = '0;
    if (state_d == ST_LOCKED) begin
      htotal_d = (state_q == ST_LOCKED) ? htotal_q : hlen;
      vtotal_d = (state_q == ST_LOCKED) ? vtotal_q : vlen;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q    <= 1'b0;
      htotal_q <= '0;
      vtotal_q <= '0;
    end else begin
      err_q    <= err_d;
      htotal_q <= htotal_d;
      vtotal_q <= vtotal_d;
    end
  end

  assign bus.HCNT   = hcnt_q;
  assign bus.VCNT   = vcnt_q;
  assign bus.HTOTAL = htotal_q;
  assign bus.VTOTAL = vtotal_q;
  assign bus.LOCKED = (state_q == ST_LOCKED);
  assign bus.ERR    = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a shortened raster (100 clk x 25 lines) so that
// many frames fit in a short run; the 2047-clock HCNT saturation is exercised in full.
module tb_vga_sync_decoder;

  localparam int HL       = 100;  // clocks per line
  localparam int NL       = 25;   // lines per frame
  localparam int HS_LOW   = 12;   // HSYNC low width in clocks
  localparam int VS_LINES = 2;    // VSYNC low width in lines

  logic clk;
  logic rst;
  int   checks      = 0;
  int   errors      = 0;
  int   err_pulses  = 0;
  int   long_line   = -1;
  int   vs_early    = 0;

  vga_sync_decoder_if #(.HW(11), .VW(10)) bus ();

  vga_sync_decoder #(.HW(11), .VW(10), .LOCK_FRAMES(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.ERR === 1'b1) err_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int line_len(input int ln);
    return (ln == long_line) ? HL + 1 : HL;
  endfunction

  function automatic logic vs_level(input int ln, input int c);
    if (ln < VS_LINES) return 1'b0;
    if (vs_early > 0 && ln == NL - 1 && c >= line_len(ln) - vs_early) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_clk(input logic hs, input logic vs);
    @(posedge clk);
    #1;
    bus.HSYNC_IN = hs;
    bus.VSYNC_IN = vs;
  endtask

  task automatic drive_line(input int ln, input int c0, input int c1);
    for (int c = c0; c < c1; c++)
      drive_clk((c < HS_LOW) ? 1'b0 : 1'b1, vs_level(ln, c));
  endtask

  task automatic send_lines(input int ln0, input int ln1);
    for (int ln = ln0; ln < ln1; ln++) drive_line(ln, 0, line_len(ln));
  endtask

  task automatic finish_frame();
    drive_line(0, 4, HL);
    send_lines(1, NL);
  endtask

  // Start of line 0: pin falls after P0, counters react at P3.
  task automatic boundary(input string tag, input int pre_vcnt, input logic pre_lock,
                          input logic post_lock, input logic post_err);
    drive_line(0, 0, 3);
    @(negedge clk);
    check({tag, "_pre_hcnt"}, 32'(bus.HCNT), HL - 1);
    check({tag, "_pre_vcnt"}, 32'(bus.VCNT), pre_vcnt);
    check({tag, "_pre_lock"}, 32'(bus.LOCKED), 32'(pre_lock));
    drive_line(0, 3, 4);
    @(negedge clk);
    check({tag, "_hcnt0"}, 32'(bus.HCNT), 0);
    check({tag, "_vcnt0"}, 32'(bus.VCNT), 0);
    check({tag, "_lock"}, 32'(bus.LOCKED), 32'(post_lock));
    check({tag, "_err"}, 32'(bus.ERR), 32'(post_err));
  endtask

  task automatic check_totals(input string tag, input int ht, input int vt);
    check({tag, "_htotal"}, 32'(bus.HTOTAL), ht);
    check({tag, "_vtotal"}, 32'(bus.VTOTAL), vt);
  endtask

  initial begin
    int sat_at;
    rst = 1'b1;
    bus.HSYNC_IN = 1'b1;
    bus.VSYNC_IN = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hcnt", 32'(bus.HCNT), 0);
    check("rst_vcnt", 32'(bus.VCNT), 0);
    check_totals("rst", 0, 0);
    check("rst_lock", 32'(bus.LOCKED), 0);
    check("rst_err", 32'(bus.ERR), 0);
    rst = 1'b0;

    // Acquire starting mid-frame: ev1/ev2 mismatch, ev3 first good, ev4 locks.
    send_lines(10, NL);
    boundary("ev1", 15, 1'b0, 1'b0, 1'b0);
    finish_frame();
    boundary("ev2", NL - 1, 1'b0, 1'b0, 1'b0);
    finish_frame();
    boundary("ev3", NL - 1, 1'b0, 1'b0, 1'b0);
    check_totals("ev3", 0, 0);
    finish_frame();
    boundary("ev4", NL - 1, 1'b0, 1'b1, 1'b0);
    check_totals("ev4", HL, NL);
    check("ev4_no_err", err_pulses, 0);

    // HCNT clears exactly three clocks after the pin edge; VCNT steps only on hs_fall.
    drive_line(0, 4, HL);
    drive_line(1, 0, 3);
    @(negedge clk);
    check("l1_pre_hcnt", 32'(bus.HCNT), HL - 1);
    check("l1_pre_vcnt", 32'(bus.VCNT), 0);
    drive_line(1, 3, 4);
    @(negedge clk);
    check("l1_hcnt0", 32'(bus.HCNT), 0);
    check("l1_vcnt", 32'(bus.VCNT), 1);
    drive_line(1, 4, 50);
    @(negedge clk);
    check("l1_mid_hcnt", 32'(bus.HCNT), 46);
    check("l1_mid_vcnt", 32'(bus.VCNT), 1);
    drive_line(1, 50, HL);
    send_lines(2, NL);

    // One 101-clock line drops lock at the end of that frame, then relock in two frames.
    long_line = 10;
    boundary("ev5", NL - 1, 1'b1, 1'b1, 1'b0);
    finish_frame();
    long_line = -1;
    boundary("ev6", NL - 1, 1'b1, 1'b0, 1'b1);
    check_totals("ev6", 0, 0);
    drive_line(0, 4, 5);
    @(negedge clk);
    check("ev6_err_done", 32'(bus.ERR), 0);
    check("ev6_pulses", err_pulses, 1);
    drive_line(0, 5, HL);
    send_lines(1, NL);
    boundary("ev7", NL - 1, 1'b0, 1'b0, 1'b0);
    finish_frame();
    boundary("ev8", NL - 1, 1'b0, 1'b1, 1'b0);
    check_totals("ev8", HL, NL);

    // VSYNC 5 clocks ahead of HSYNC, then coincident: both restart VCNT on line 0.
    vs_early = 5;
    finish_frame();
    vs_early = 0;
    boundary("ev9", NL - 1, 1'b1, 1'b1, 1'b0);
    finish_frame();
    boundary("ev10", NL - 1, 1'b1, 1'b1, 1'b0);

    // Reset pulse mid-frame while locked.
    drive_line(0, 4, HL);
    send_lines(1, 12);
    drive_line(12, 0, 50);
    rst = 1'b1;
    drive_line(12, 50, 51);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_hcnt", 32'(bus.HCNT), 0);
    check("mrst_vcnt", 32'(bus.VCNT), 0);
    check_totals("mrst", 0, 0);
    check("mrst_lock", 32'(bus.LOCKED), 0);
    check("mrst_err", 32'(bus.ERR), 0);
    drive_line(12, 51, HL);
    send_lines(13, NL);
    boundary("ev11", 12, 1'b0, 1'b0, 1'b0);
    finish_frame();
    boundary("ev12", NL - 1, 1'b0, 1'b0, 1'b0);
    finish_frame();
    boundary("ev13", NL - 1, 1'b0, 1'b0, 1'b0);
    finish_frame();
    boundary("ev14", NL - 1, 1'b0, 1'b1, 1'b0);
    check_totals("ev14", HL, NL);
    check("ev14_pulses", err_pulses, 1);

    // HSYNC stops: HCNT saturates 2047 clocks after its last clear, then lock is lost.
    sat_at = -1;
    for (int n = 0; n < 2200; n++) begin
      drive_clk(1'b1, 1'b0);
      @(negedge clk);
      if (bus.HCNT == 11'h7FF) begin
        sat_at = n;
        break;
      end
    end
    check("sat_time", sat_at, 2046);
    check("sat_lock_pre", 32'(bus.LOCKED), 1);
    drive_clk(1'b1, 1'b0);
    @(negedge clk);
    check("to_lock", 32'(bus.LOCKED), 0);
    check("to_err", 32'(bus.ERR), 1);
    check("to_hcnt", 32'(bus.HCNT), 2047);
    check_totals("to", 0, 0);
    drive_clk(1'b1, 1'b0);
    @(negedge clk);
    check("to_err_done", 32'(bus.ERR), 0);
    check("to_lock_hold", 32'(bus.LOCKED), 0);
    check("to_pulses", err_pulses, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
